// File: rtl/coef_mult_if.sv
// Operand/product handshake bundle for coef_mult.
// Master drives operands and consumes products; slave is the multiplier.
interface coef_mult_if #(
  parameter int W = 12
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_c;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_c
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_c
  );
endinterface

// File: rtl/coef_mult.sv
// Two-stage W x W unsigned coefficient multiplier with valid/ready flow,
// sticky operand range flag and product handshake counter.
module coef_mult #(
  parameter int W = 12,
  parameter int Q = 3329
) (
  input  logic        clk,
  input  logic        rst_n,
  coef_mult_if.slave  bus,
  input  logic        err_clr,
  output logic        err,
  output logic [15:0] prod_cnt
);
  localparam int H  = W / 2;
  localparam int HH = W - H;
  localparam logic [W:0] QV = (W+1)'(Q);

  logic             advance;
  logic             acc;
  logic             fire;
  logic             bad;
  logic             s1_valid;
  logic [W+H-1:0]   p_lo;
  logic [W+HH-1:0]  p_hi;
  logic [2*W-1:0]   sum;

  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;
  assign acc          = bus.in_valid && advance;
  assign fire         = bus.out_valid && bus.out_ready;

  assign bad = ({1'b0, bus.in_a} >= QV)
            || ({1'b0, bus.in_b} >= QV);

  // Recombine the two half-width partial products.
  assign sum = (2*W)'(p_lo)
             + ((2*W)'(p_hi) << H);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      p_lo     <= '0;
      p_hi     <= '0;
    end else if (advance) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        p_lo <= (W+H)'(bus.in_a)
              * (W+H)'(bus.in_b[H-1:0]);
        p_hi <= (W+HH)'(bus.in_a)
              * (W+HH)'(bus.in_b[W-1:H]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_c     <= '0;
    end else if (advance) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_c <= sum;
      end
    end
  end

  // A fresh violation beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (acc && bad) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_cnt <= '0;
    end else if (fire) begin
      prod_cnt <= prod_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_coef_mult.sv
// Scoreboard bench for coef_mult: latency, streaming, stall,
// range flag, mid-stream reset and counter wrap.
module tb_coef_mult;
  localparam int W = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        err_clr = 1'b0;
  logic        err;
  logic [15:0] prod_cnt;

  int checks = 0;
  int errors = 0;
  int nhs = 0;

  logic [2*W-1:0] sb[$];

  always #5 clk = ~clk;

  coef_mult_if #(.W(W)) bus ();

  coef_mult #(.W(W), .Q(3329)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave),
    .err_clr(err_clr),
    .err(err),
    .prod_cnt(prod_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Handshakes are sampled mid-cycle; inputs only move after posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 32'(bus.out_c), 32'hDEAD);
        end else begin
          chk("out_c", 32'(bus.out_c), 32'(sb.pop_front()));
          nhs++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back((2*W)'(bus.in_a) * (2*W)'(bus.in_b));
      end
    end
  end

  task automatic send(input logic [W-1:0] a,
                      input logic [W-1:0] b);
    logic ok;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    for (int n = 0; n <= 100; n++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      if (n == 100) chk("send_timeout", 0, 1);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 60; n++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    int n0;
    int nb;
    int stale;
    logic [2*W-1:0] held;

    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_c", 32'(bus.out_c), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_cnt", 32'(prod_cnt), 0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 1);

    // basic latency
    send(12'd3328, 12'd3328);
    chk("lat_c1_valid", 32'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_c2_valid", 32'(bus.out_valid), 1);
    chk("lat_c2_out_c", 32'(bus.out_c), 32'hA90000);
    @(posedge clk);
    #1;
    chk("lat_c3_valid", 32'(bus.out_valid), 0);
    chk("lat_cnt", 32'(prod_cnt), 1);
    chk("lat_err", 32'(err), 0);

    // streaming without bubbles
    nb = 0;
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin
        send(W'(k), W'(k + 1));
      end else begin
        @(posedge clk);
        #1;
      end
      if (k >= 1 && k <= 8) nb += int'(bus.out_valid);
    end
    drain();
    chk("stream_nobubble", nb, 8);
    chk("stream_cnt", 32'(prod_cnt), 9);

    // backpressure
    n0 = nhs;
    fork
      begin
        for (int i = 0; i < 10; i++) send(W'(100 + i), W'(7 * i));
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        held = bus.out_c;
        for (int s = 0; s < 5; s++) begin
          @(posedge clk);
          #1;
          chk("stall_in_ready", 32'(bus.in_ready), 0);
          chk("stall_out_valid", 32'(bus.out_valid), 1);
          chk("stall_out_c", 32'(bus.out_c), 32'(held));
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", nhs - n0, 10);
    chk("bp_cnt", 32'(prod_cnt), 19);

    // range check and sticky flag
    chk("range_err_pre", 32'(err), 0);
    send(12'd3329, 12'd1);
    chk("range_err_set", 32'(err), 1);
    err_clr = 1'b1;
    send(12'd4095, 12'd0);
    err_clr = 1'b0;
    chk("range_set_wins", 32'(err), 1);
    drain();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    chk("range_err_clr", 32'(err), 0);

    // reset with products in flight
    send(12'd5, 12'd6);
    send(12'd7, 12'd8);
    chk("mid_pre_valid", 32'(bus.out_valid), 1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("mid_out_valid", 32'(bus.out_valid), 0);
    chk("mid_cnt", 32'(prod_cnt), 0);
    chk("mid_out_c", 32'(bus.out_c), 0);
    chk("mid_in_ready", 32'(bus.in_ready), 1);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    stale = 0;
    for (int s = 0; s < 6; s++) begin
      @(posedge clk);
      #1;
      stale += int'(bus.out_valid);
    end
    chk("mid_no_stale", stale, 0);
    chk("mid_cnt_after", 32'(prod_cnt), 0);

    // counter wrap
    n0 = nhs;
    for (int i = 0; i < 65536; i++) begin
      send(W'(i), ~W'(i >> 3));
    end
    drain();
    chk("wrap_hs", nhs - n0, 65536);
    chk("wrap_cnt", 32'(prod_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
